alu_mdu: RTL

Parametrised, handshaked execute-stage ALU that extends the single-cycle integer ALU with shifts, signed/unsigned compare, and iterative unsigned multiply and divide. Operands are accepted on a valid/ready handshake; single-cycle ops produce a registered result one cycle later; multiply and divide run a WIDTH-step shift-add or restoring-division datapath. The EX stage stalls on `in_ready`/`out_valid` while a multi-cycle op is in flight.

---
 rtl/alu_mdu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute-stage ALU with iterative unsigned multiply and divide.
// Single-cycle ops register their result at accept; multu/divu iterate WIDTH cycles.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | multu/divu iterating, one bit per cycle
    // DONE  | result held until out_ready
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [SHW:0]     cnt, cnt_nxt;
    logic             is_div, is_div_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] mq, mq_nxt;
    logic [WIDTH-1:0] opd, opd_nxt;
    logic [WIDTH-1:0] result_nxt, result_hi_nxt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;
    logic [SHW-1:0]   shamt;

    assign shamt     = b[SHW-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // acc holds the running high product / partial remainder; mq the multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, {WIDTH{mq[0]}} & opd};
        div_shift = {acc, mq[WIDTH-1]};
        div_fits  = div_shift >= {1'b0, opd};
        div_diff  = div_shift[WIDTH-1:0] - opd;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        is_div_nxt    = is_div;
        acc_nxt       = acc;
        mq_nxt        = mq;
        opd_nxt       = opd;
        result_nxt    = result;
        result_hi_nxt = result_hi;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (alu_ctrl == OP_MULTU || alu_ctrl == OP_DIVU) begin
                        is_div_nxt = (alu_ctrl == OP_DIVU);
                        acc_nxt    = '0;
                        mq_nxt     = (alu_ctrl == OP_DIVU) ? a : b;
                        opd_nxt    = (alu_ctrl == OP_DIVU) ? b : a;
                        cnt_nxt    = ITERS;
                        state_nxt  = RUN;
                    end else begin
                        result_nxt    = alu_res;
                        result_hi_nxt = '0;
                        state_nxt     = DONE;
                    end
                end
            end
            RUN: begin
                if (is_div) begin
                    acc_nxt = div_fits ? div_diff : div_shift[WIDTH-1:0];
                    mq_nxt  = {mq[WIDTH-2:0], div_fits};
                end else begin
                    acc_nxt = mul_sum[WIDTH:1];
                    mq_nxt  = {mul_sum[0], mq[WIDTH-1:1]};
                end
                cnt_nxt = cnt - 1'b1;
                if (cnt_nxt == '0) begin
                    result_nxt    = mq_nxt;
                    result_hi_nxt = acc_nxt;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            acc       <= '0;
            mq        <= '0;
            opd       <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_div    <= is_div_nxt;
            acc       <= acc_nxt;
            mq        <= mq_nxt;
            opd       <= opd_nxt;
            result    <= result_nxt;
            result_hi <= result_hi_nxt;
            zero      <= (result_nxt == '0);
        end
    end
endmodule
